// File: rtl/run_cnt_core.sv
// run_cnt_core
//
// This block counts a programmed number of cycles after each start request.
// It is a Moore FSM, so every output is decoded from registered state only.
// When a run is accepted with a target N, o_cnt_val stays high for N cycles
// and o_cnt steps 0..N-1. A one-cycle o_done pulse follows, and then the
// block returns to idle. A target of 0 goes straight to the done pulse.
//
// Parameters
//   CNT_WIDTH   width of the count target and of the count output (default 7)
//
// Ports
//   clk         clock; all state changes on the rising edge
//   reset_n     synchronous active-low reset
//   i_run       start request, sampled only while idle
//   i_num_cnt   number of counts, captured together with an accepted i_run
//   i_abort     (only when RUN_CNT_ABORT_EN is defined) ends a run early,
//               returning to idle without a done pulse
//   o_idle      high in S_IDLE
//   o_running   high in S_RUN
//   o_done      one-cycle completion pulse, high in S_DONE
//   o_cnt_val   qualifies o_cnt, high in S_RUN
//   o_cnt       current count, zero when o_cnt_val is low
//
// Build option
//   RUN_CNT_ABORT_EN  adds the i_abort port and the early-exit path
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for i_run; a nonzero target starts a run
// S_RUN  | counting 0..num_reg-1, one step per cycle
// S_DONE | single-cycle completion pulse, then back to S_IDLE
// 2'b11  | unencoded; recovers to S_IDLE with all outputs low

module run_cnt_core #(
    parameter int CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_num_cnt,
`ifdef RUN_CNT_ABORT_EN
    input  logic                 i_abort,
`endif
    output logic                 o_idle,
    output logic                 o_running,
    output logic                 o_done,
    output logic                 o_cnt_val,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH-1:0] num_reg;
    logic [CNT_WIDTH-1:0] num_next;
    logic                 last_cnt;
    logic                 abort_req;

`ifdef RUN_CNT_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    // num_reg is never zero in S_RUN, so num_reg-1 cannot underflow there.
    assign last_cnt = (cnt_reg == (num_reg - CNT_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            num_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            num_reg   <= num_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        num_next   = num_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_run) begin
                    if (i_num_cnt != '0) begin
                        num_next   = i_num_cnt;
                        cnt_next   = '0;
                        state_next = S_RUN;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // Abort takes priority over finishing on the last count.
                if (abort_req) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else if (last_cnt) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_idle    = (state_reg == S_IDLE);
    assign o_running = (state_reg == S_RUN);
    assign o_done    = (state_reg == S_DONE);
    assign o_cnt_val = (state_reg == S_RUN);
    assign o_cnt     = (state_reg == S_RUN) ? cnt_reg : '0;

endmodule
